// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter/rotator with valid/ready flow control.
// Shift levels are spread over STAGES registers, MSB level first.
module shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [2:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err
);

  localparam int L   = $clog2(WIDTH);
  localparam int PER = (L + STAGES - 1) / STAGES;
  localparam int LS  = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [L-1:0]     amt;
    logic [2:0]       mode;
    logic             msb;
    logic [TAG_W-1:0] tag;
    logic             err;
  } slot_t;

  slot_t sq [STAGES];
  slot_t sd [STAGES];
  slot_t sn [STAGES];
  logic  vq [STAGES];
  logic  adv;

  function automatic logic [WIDTH-1:0] rev(
    input logic [WIDTH-1:0] x
  );
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++)
      r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  function automatic logic is_left(
    input logic [2:0] m
  );
    return m[1:0] == 2'b00;
  endfunction

  function automatic logic illegal(
    input logic [2:0] m
  );
    return (m == 3'b010) || (m[2:1] == 2'b11);
  endfunction

  // Upper half is the fill source: the operand itself for rotates.
  function automatic logic [WIDTH-1:0] shr(
    input logic [WIDTH-1:0] x,
    input int               s,
    input logic             rot,
    input logic             fill
  );
    logic [2*WIDTH-1:0] e;
    e = {(rot ? x : {WIDTH{fill}}), x} >> s;
    return e[WIDTH-1:0];
  endfunction

  always_comb begin
    sd[0].data = is_left(in_mode) ? rev(in_data)
                                  : in_data;
    sd[0].amt  = in_amt;
    sd[0].mode = in_mode;
    sd[0].msb  = in_data[WIDTH-1];
    sd[0].tag  = in_tag;
    sd[0].err  = illegal(in_mode);
    for (int k = 1; k < STAGES; k++)
      sd[k] = sq[k-1];
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sn[k] = sd[k];
      for (int j = 0; j < L; j++) begin
        if ((j / PER) == k && sd[k].amt[L-1-j])
          sn[k].data = shr(sn[k].data,
                           1 << (L - 1 - j),
                           sd[k].mode[2],
                           sd[k].msb &&
                           sd[k].mode == 3'b011);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vq[k] <= 1'b0;
        sq[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++)
        vq[k] <= 1'b0;
    end else if (adv) begin
      vq[0] <= in_valid;
      for (int k = 1; k < STAGES; k++)
        vq[k] <= vq[k-1];
      for (int k = 0; k < STAGES; k++)
        sq[k] <= sn[k];
    end
  end

  assign out_valid = vq[LS];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_tag   = sq[LS].tag;
  assign out_err   = sq[LS].err;
  assign out_data  = sq[LS].err ? '0 :
                     is_left(sq[LS].mode) ? rev(sq[LS].data)
                                          : sq[LS].data;

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: scoreboard bench for shift_pipe.
// Driver pushes model results; monitor pops on each output handshake.
module tb_shift_pipe;
  parameter int STAGES = 2;
  localparam int W  = 32;
  localparam int TW = 5;
  localparam int AW = 5;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          flush = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic [2:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 0;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_err;

  shift_pipe #(.WIDTH(W), .STAGES(STAGES), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [TW-1:0] t;
    logic          e;
    int            c;
    bit            x;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic logic bad_mode(input logic [2:0] m);
    return m == 3'b010 || m == 3'b110 || m == 3'b111;
  endfunction

  function automatic logic [W-1:0] model(
    input logic [W-1:0] d, input int n, input logic [2:0] m);
    logic signed [W-1:0] s;
    s = d;
    case (m)
      3'b000:  return d << n;
      3'b001:  return d >> n;
      3'b011:  return s >>> n;
      3'b100:  return (d << n) | (d >> (W - n));
      3'b101:  return (d >> n) | (d << (W - n));
      default: return '0;
    endcase
  endfunction

  task automatic drive(
    input bit v, input logic [W-1:0] d, input int a,
    input logic [2:0] m, input logic [TW-1:0] t,
    input bit ordy, input bit fl, input bit ex,
    input logic [W-1:0] ed, input logic ee,
    output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_data = d; in_amt = a[AW-1:0];
    in_mode = m; in_tag = t;
    out_ready = ordy && !fl; flush = fl;
    if (fl) q.delete();
    #1;
    acc = v && in_ready && !fl;
    if (acc) begin
      e.d = ed; e.t = t; e.e = ee; e.c = cyc; e.x = ex;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) drive(0, '0, 0, 3'b000, '0, 1, 0, 0, '0, 0, acc);
  endtask

  task automatic rand_op(input bit v, input bit ordy, input bit fl,
                         input bit legal, output bit acc);
    logic [W-1:0] d;
    logic [2:0] m;
    int a, r;
    logic [2:0] lm [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
    r = $urandom_range(0, 7);
    a = (r == 0) ? 0 : (r == 1) ? W - 1 : $urandom_range(0, W - 1);
    r = $urandom_range(0, 5);
    d = (r == 0) ? '1 : (r == 1) ? 32'h8000_0000 : $urandom;
    m = legal ? lm[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
    drive(v, d, a, m, TW'($urandom), ordy, fl, 0,
          model(d, a, m), bad_mode(m), acc);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_data"},  out_data,  0);
    chk({nm, "_tag"},   out_tag,   0);
    chk({nm, "_err"},   out_err,   0);
    chk({nm, "_ready"}, in_ready,  1);
  endtask

  // Monitor: decoupled from stimulus, compares on each retiring output.
  initial begin
    bit hold = 0;
    logic [W+TW:0] hv = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 0;
        continue;
      end
      if (hold && out_valid)
        chk("hold_stable", {out_err, out_tag, out_data}, hv);
      if (out_valid && out_ready) begin
        chk("spurious", q.size() == 0, 0);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("data", out_data, e.d);
          chk("tag", out_tag, e.t);
          chk("err", out_err, e.e);
          if (e.x) chk("latency", cyc - e.c, STAGES);
          else chk("latency_min", (cyc - e.c) >= STAGES, 1);
        end
      end
      hold = out_valid && !out_ready;
      hv = {out_err, out_tag, out_data};
    end
  end

  initial begin
    bit acc;
    int k;
    bit ordy;
    #1;
    chk_reset("rst");
    repeat (2) @(negedge clk);
    rst_n = 1;

    drive(1, 32'h8000_00F0, 4, 3'b011, 7, 1, 0, 1,
          32'hF800_000F, 0, acc);
    drive(1, 32'h8000_0001, 1, 3'b100, 1, 1, 0, 1,
          32'h0000_0003, 0, acc);
    drive(1, 32'h0000_0001, 31, 3'b101, 2, 1, 0, 1,
          32'h0000_0002, 0, acc);
    drive(1, 32'hFFFF_FFFF, 31, 3'b000, 4, 1, 0, 1,
          32'h8000_0000, 0, acc);
    drive(1, 32'h1234_5678, 9, 3'b110, 3, 1, 0, 1,
          32'h0000_0000, 1, acc);
    idle(STAGES + 2);

    k = 0;
    for (int i = 0; i < 20 && k < 8; i++) begin
      ordy = !(i >= 3 && i <= 5);
      rand_op(1, ordy, 0, 1, acc);
      chk("in_ready", in_ready, ordy || !out_valid);
      if (acc) k++;
    end
    chk("stream_issued", k, 8);
    idle(STAGES + 3);

    rand_op(1, 0, 0, 1, acc);
    rand_op(1, 0, 0, 1, acc);
    rand_op(1, 0, 1, 1, acc);
    for (int i = 0; i < STAGES + 2; i++) begin
      drive(0, '0, 0, 3'b000, '0, 1, 0, 0, '0, 0, acc);
      chk("flush_drop", out_valid, 0);
    end
    drive(1, 32'h0000_00F0, 4, 3'b001, 9, 1, 0, 1,
          32'h0000_000F, 0, acc);
    idle(STAGES + 2);
    chk("post_flush_drain", q.size(), 0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        @(negedge clk);
        in_valid = 0; flush = 0; out_ready = 0;
        #3 rst_n = 0;
        #1 chk_reset("async_rst");
        q.delete();
        @(posedge clk);
        #2 rst_n = 1;
      end
      rand_op($urandom_range(0, 3) != 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 49) == 0, 0, acc);
    end
    idle(STAGES + 4);
    chk("final_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
